// File: rtl/apb_rr_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_ctrl_pkg
// Purpose : shared types and constants for the APB round-robin master and the
//           environments that talk to it.
// Contents: state_t   - transfer sequencer states
//           REG0_ADDR - address of the 10-bit data register in the APB target
//           REG1_ADDR - address of the write-only register in the APB target
// -----------------------------------------------------------------------------
package apb_ctrl_pkg;

  // IDLE    : waiting for a request, arbitration happens here
  // SETUP   : psel high, penable low
  // ACCESS  : psel and penable high, target samples/drives the transfer
  // CAPTURE : read only, target's registered prdata is sampled at cycle end
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [7:0] REG0_ADDR = 8'h00;
  localparam logic [7:0] REG1_ADDR = 8'h04;

endpackage

// File: rtl/apb_rr_master_if.sv
// -----------------------------------------------------------------------------
// apb_rr_master_if
// Purpose : bundles the requester-side handshake and the APB bus of the
//           round-robin APB master into one interface.
// Signals : req_valid/req_ready/req_write/req_addr/req_wdata - requester ports,
//           flattened, requester i at [i*W +: W]
//           rsp_valid/rsp_rdata - completion pulse and captured read data
//           busy                - transfer in progress
//           paddr/pwrite/psel/penable/pwdata/prdata - APB bus
// Modports: master - the view of apb_rr_master
//           slave  - the view of the environment (requesters + APB target)
// -----------------------------------------------------------------------------
interface apb_rr_master_if #(
  parameter int NREQ  = 2,
  parameter int ADDRW = 8,
  parameter int DATAW = 32
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_write;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*DATAW-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [DATAW-1:0]      rsp_rdata;
  logic                  busy;

  logic [ADDRW-1:0]      paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATAW-1:0]      pwdata;
  logic [DATAW-1:0]      prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
           paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           paddr, pwrite, psel, penable, pwdata
  );

endinterface

// File: rtl/apb_rr_master_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purpose : purely combinational round-robin pick. Searches the request vector
//           starting one position after the pointer (wrapping) and returns the
//           first requester found.
// Ports   : i_req   - request vector
//           i_ptr   - index of the most recently granted requester
//           o_grant - one-hot grant (all zero when nothing requests)
//           o_idx   - binary index of the granted requester
//           o_any   - at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  // w_cand[k] is the requester examined at search position k: ptr+1, ptr+2, ...
  logic [IDXW-1:0] w_cand [NREQ];
  logic            w_found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign w_cand[gi] = IDXW'((int'(i_ptr) + gi + 1) % NREQ);
    end
  endgenerate

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req[w_cand[k]]) begin
        w_found             = 1'b1;
        o_idx               = w_cand[k];
        o_grant[w_cand[k]]  = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/apb_rr_master.sv
// -----------------------------------------------------------------------------
// apb_rr_master
// Purpose : shares one APB register target between NREQ requesters. Picks a
//           requester round-robin, runs the APB SETUP/ACCESS phases and, for
//           reads, spends one extra CAPTURE cycle because the target registers
//           prdata one cycle after ACCESS.
// Ports   : clk - clock, all logic on posedge
//           rst - asynchronous active-high reset
//           bus - apb_rr_master_if.master: requester handshake, completion
//                 pulse, read data, busy flag and the APB bus
// Timing  : accept cycle = 0, SETUP = 1, ACCESS = 2,
//           write completes at 3, read completes at 4.
// -----------------------------------------------------------------------------
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int ADDRW = 8,
  parameter int DATAW = 32
) (
  input logic             clk,
  input logic             rst,
  apb_rr_master_if.master bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Sequencer state
  state_t           r_state;
  state_t           w_state_next;

  // Arbitration
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  w_idx;
  logic [NREQ-1:0]  w_grant;
  logic             w_any;
  logic [NREQ-1:0]  r_grant;     // owner of the transfer in flight

  // Registered outputs
  logic [ADDRW-1:0] r_paddr;
  logic             r_pwrite;
  logic [DATAW-1:0] r_pwdata;
  logic             r_psel;
  logic             r_penable;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [DATAW-1:0] r_rsp_rdata;

  // Next-value strobes from the output decoder
  logic             w_accept;
  logic             w_capture;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_psel_next;
  logic             w_penable_next;
  logic [NREQ-1:0]  w_rsp_valid_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  w_state_next = r_pwrite ? IDLE : CAPTURE;
      CAPTURE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. APB controls are decoded from the next state so that
  // the registered psel/penable line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    // Never advertise an accept while reset holds the sequencer in IDLE,
    // otherwise a requester would believe a dropped request was taken.
    w_accept         = (r_state == IDLE) && w_any && !rst;
    w_req_ready      = w_accept ? w_grant : '0;
    w_psel_next      = (w_state_next == SETUP) || (w_state_next == ACCESS);
    w_penable_next   = (w_state_next == ACCESS);
    w_capture        = (r_state == CAPTURE);
    w_rsp_valid_next = '0;
    // Completion is flagged on the way back to IDLE: after ACCESS for a
    // write, after CAPTURE for a read.
    if (((r_state == ACCESS) && r_pwrite) || (r_state == CAPTURE)) begin
      w_rsp_valid_next = r_grant;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= IDXW'(NREQ - 1);    // requester 0 wins the first grant
      r_grant     <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_psel      <= w_psel_next;
      r_penable   <= w_penable_next;
      r_rsp_valid <= w_rsp_valid_next;
      // Request fields are sampled only here and then held until the next
      // grant, keeping the APB address/data stable through CAPTURE.
      if (w_accept) begin
        r_ptr    <= w_idx;
        r_grant  <= w_grant;
        r_paddr  <= bus.req_addr[int'(w_idx)*ADDRW +: ADDRW];
        r_pwrite <= bus.req_write[w_idx];
        r_pwdata <= bus.req_wdata[int'(w_idx)*DATAW +: DATAW];
      end
      if (w_capture) begin
        r_rsp_rdata <= bus.prdata;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;

endmodule
